pif_multi_flasher: RTL and testbench
====================================

PIF_MULTI_FLASHER -- requirements
Module: pif_multi_flasher

Interface
REQ-001 SHALL have parameter NCH, default 2: number of LED channels, 1..16.
REQ-002 SHALL have parameter CW, default 16: phase-counter width in bits.
REQ-003 SHALL have parameter PRESCALE, default 1000: xclk cycles per tick, >=2.
REQ-004 SHALL have parameter PW, default 8: PWM resolution in bits.
REQ-005 SHALL have port xclk, input, 1 bit: sole clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_valid, input, 1 bit: configuration write request.
REQ-008 SHALL have port cfg_ready, output, 1 bit: write can be accepted.
REQ-009 SHALL have port cfg_ch, input, max(1,$clog2(NCH)) bits: target channel.
REQ-010 SHALL have port cfg_mode, input, 2 bits: 0 OFF, 1 SOLID, 2 BLINK, 3 PWM_BLINK.
REQ-011 SHALL have port cfg_on, input, CW bits: ON-phase length in ticks.
REQ-012 SHALL have port cfg_off, input, CW bits: OFF-phase length in ticks.
REQ-013 SHALL have port cfg_duty, input, PW bits: PWM duty for PWM_BLINK.
REQ-014 SHALL have port led, output, NCH bits: registered per-channel LED drive, 1 = lit.
REQ-015 SHALL have port tick, output, 1 bit: registered one-cycle prescaler strobe.

Function
REQ-016 Prescaler SHALL count 0..PRESCALE-1 on xclk and assert tick for exactly one cycle when wrapping from PRESCALE-1 to 0; first tick on cycle PRESCALE after reset release.
REQ-017 cfg_ready SHALL be 1 in every cycle outside reset; a write is accepted when cfg_valid && cfg_ready.
REQ-018 Accepted write with cfg_ch >= NCH SHALL be discarded with no state change.
REQ-019 Accepted write SHALL latch mode/on/off/duty into the channel and restart it in ON_PH with counter = max(cfg_on,1); led reflects new config on the following cycle.
REQ-020 Per-channel FSM states SHALL be IDLE, ON_PH, OFF_PH.
REQ-021 IDLE: mode OFF; led=0; no transitions on tick.
REQ-022 SOLID: channel stays in ON_PH; led=1; counter frozen.
REQ-023 BLINK/PWM_BLINK: counter decrements on tick; on tick with counter==1, ON_PH->OFF_PH reloading max(off,1), OFF_PH->ON_PH reloading max(on,1).
REQ-024 Zero on/off length SHALL be treated as 1 tick (no zero-length phase, no underflow).
REQ-025 Free-running PW-bit PWM counter SHALL wrap 2^PW-1 -> 0; in PWM_BLINK ON_PH led = (pwm_cnt < duty); duty=0 is always dark, duty=2^PW-1 lights 2^PW-1 of 2^PW cycles.
REQ-026 OFF_PH SHALL drive led=0 in all modes.
REQ-027 Write and tick in the same cycle for the same channel: write SHALL win, tick ignored for that channel.
REQ-028 Channels SHALL be independent; a write to one SHALL not disturb any other's phase or counter.

Reset
REQ-029 While sys_rst=0, led=0, tick=0, cfg_ready=0, prescaler=0, PWM counter=0, all channels IDLE, mode OFF, counters 0.
REQ-030 Reset asserted mid-phase SHALL clear all state immediately, without waiting for xclk; config is not retained.
REQ-031 Deassertion SHALL be synchronised to xclk; first accepted write occurs no earlier than the second xclk edge after release.

Structure
REQ-032 Mode encodings and FSM state encodings SHALL live in shared package pif_flasher_pkg.
REQ-033 One per-channel sub-module pif_flasher_chan (FSM, phase counter, PWM compare) SHALL be instantiated NCH times; prescaler, PWM counter and write decode in the top level.

Verification (NCH=2, CW=8, PRESCALE=4, PW=4)
REQ-034 Reset release, no writes -> tick high on cycles 4, 8, 12...; led=00 throughout.
REQ-035 Write ch0 BLINK on=2 off=3 -> led[0] high 8 cycles, low 12 cycles, repeating; led[1]=0.
REQ-036 Write ch1 PWM_BLINK on=1 off=1 duty=4 -> during ON_PH led[1] high 4 of every 16 cycles; duty=0 -> always low.
REQ-037 Write ch0 on=0 off=0 BLINK -> phases of 1 tick each, no stall; write cfg_ch=2 -> no change.
REQ-038 Write ch0 coincident with tick -> channel restarts ON_PH with fresh count; ch1 phase unaffected.
REQ-039 Assert sys_rst mid-ON_PH between clock edges -> led=00 immediately; after release channels IDLE until rewritten.

Source files
------------

// File: rtl/pif_flasher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pif_flasher_pkg
// Description : Shared encodings for the multi-channel LED flasher: channel
//               mode codes, per-channel FSM state codes and a helper that
//               sizes the channel-select field.
// Revision    : 1.0 - initial release
// ============================================================================
package pif_flasher_pkg;

    // Mode codes as they appear on the configuration bus.
    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_SOLID     = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_PWM_BLINK = 2'd3
    } mode_e;

    // Per-channel phase state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ON_PH  = 2'd1,
        ST_OFF_PH = 2'd2
    } chan_state_e;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pif_flasher_pkg
`default_nettype wire

// File: rtl/pif_flasher_chan.sv
`default_nettype none
// ============================================================================
// Module      : pif_flasher_chan
// Description : One LED channel: configuration registers, IDLE/ON_PH/OFF_PH
//               phase FSM, tick-driven phase counter and PWM compare.
// Ports       : clk, rst_n     - clock, async active-low reset (pre-synced)
//               i_wr           - load new configuration and restart
//               i_mode/i_on/i_off/i_duty - configuration fields
//               i_tick         - prescaler strobe
//               i_pwm_nxt      - value the shared PWM counter takes this edge
//               o_led          - registered LED drive, 1 = lit
// Revision    : 1.0 - initial release
// ============================================================================
module pif_flasher_chan
    import pif_flasher_pkg::*;
#(
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [1:0]    i_mode,
    input  logic [CW-1:0] i_on,
    input  logic [CW-1:0] i_off,
    input  logic [PW-1:0] i_duty,
    input  logic          i_tick,
    input  logic [PW-1:0] i_pwm_nxt,
    output logic          o_led
);

    chan_state_e   r_state, w_state_nxt;
    mode_e         r_mode,  w_mode_nxt;
    logic [CW-1:0] r_on,    w_on_nxt;
    logic [CW-1:0] r_off,   w_off_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [PW-1:0] r_duty,  w_duty_nxt;
    logic          r_led,   w_led_nxt;
    logic          w_blinking;

    // A zero-length phase is stretched to one tick so the counter never underflows.
    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    assign w_blinking = (r_mode == MODE_BLINK) || (r_mode == MODE_PWM_BLINK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_OFF;
            r_on    <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_on    <= w_on_nxt;
            r_off   <= w_off_nxt;
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_led   <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_on_nxt    = r_on;
        w_off_nxt   = r_off;
        w_cnt_nxt   = r_cnt;
        w_duty_nxt  = r_duty;
        w_led_nxt   = 1'b0;

        // A write takes priority over a coincident tick.
        if (i_wr) begin
            w_mode_nxt  = mode_e'(i_mode);
            w_on_nxt    = i_on;
            w_off_nxt   = i_off;
            w_duty_nxt  = i_duty;
            if (mode_e'(i_mode) == MODE_OFF) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_ON_PH;
                w_cnt_nxt   = at_least_one(i_on);
            end
        end else if (i_tick && w_blinking && (r_state != ST_IDLE)) begin
            if (r_cnt <= CW'(1)) begin
                if (r_state == ST_ON_PH) begin
                    w_state_nxt = ST_OFF_PH;
                    w_cnt_nxt   = at_least_one(r_off);
                end else begin
                    w_state_nxt = ST_ON_PH;
                    w_cnt_nxt   = at_least_one(r_on);
                end
            end else begin
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end

        // LED is computed from the post-edge state so it follows a write by one cycle.
        if (w_state_nxt == ST_ON_PH) begin
            case (w_mode_nxt)
                MODE_SOLID, MODE_BLINK: w_led_nxt = 1'b1;
                MODE_PWM_BLINK:         w_led_nxt = (i_pwm_nxt < w_duty_nxt);
                default:                w_led_nxt = 1'b0;
            endcase
        end
    end

    assign o_led = r_led;

endmodule : pif_flasher_chan
`default_nettype wire

// File: rtl/pif_multi_flasher.sv
`default_nettype none
// ============================================================================
// Module      : pif_multi_flasher
// Description : NCH independent LED flasher channels sharing a tick
//               prescaler and a free-running PWM counter, configured through
//               a valid/ready write port.
// Ports       : xclk       - clock
//               sys_rst    - async active-low reset
//               cfg_valid/cfg_ready - configuration write handshake
//               cfg_ch     - target channel (writes to cfg_ch >= NCH dropped)
//               cfg_mode/cfg_on/cfg_off/cfg_duty - channel configuration
//               led        - registered LED drive per channel
//               tick       - registered one-cycle prescaler strobe
// Revision    : 1.0 - initial release
// ============================================================================
module pif_multi_flasher
    import pif_flasher_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CW       = 16,
    parameter int PRESCALE = 1000,
    parameter int PW       = 8
) (
    input  logic                      xclk,
    input  logic                      sys_rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_width(NCH)-1:0]  cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [CW-1:0]             cfg_on,
    input  logic [CW-1:0]             cfg_off,
    input  logic [PW-1:0]             cfg_duty,
    output logic [NCH-1:0]            led,
    output logic                      tick
);

    localparam int CHW = ch_width(NCH);
    localparam int PSW = $clog2(PRESCALE);

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;
    logic [PSW-1:0] r_ps;
    logic           r_tick;
    logic [PW-1:0]  r_pwm;
    logic [PW-1:0]  w_pwm_nxt;
    logic           w_accept;

    // Reset asserts asynchronously everywhere but releases two xclk edges later.
    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n   = r_rst_sync[1];
    assign cfg_ready = w_rst_n;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_pwm_nxt = r_pwm + PW'(1);

    always_ff @(posedge xclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
            r_pwm  <= '0;
        end else begin
            r_pwm <= w_pwm_nxt;
            if (r_ps == PSW'(PRESCALE - 1)) begin
                r_ps   <= '0;
                r_tick <= 1'b1;
            end else begin
                r_ps   <= r_ps + PSW'(1);
                r_tick <= 1'b0;
            end
        end
    end

    assign tick = r_tick;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic w_wr;
            // Out-of-range channel codes match no instance and are dropped.
            assign w_wr = w_accept && (cfg_ch == CHW'(gi));

            pif_flasher_chan #(
                .CW (CW),
                .PW (PW)
            ) u_chan (
                .clk       (xclk),
                .rst_n     (w_rst_n),
                .i_wr      (w_wr),
                .i_mode    (cfg_mode),
                .i_on      (cfg_on),
                .i_off     (cfg_off),
                .i_duty    (cfg_duty),
                .i_tick    (r_tick),
                .i_pwm_nxt (w_pwm_nxt),
                .o_led     (led[gi])
            );
        end
    endgenerate

endmodule : pif_multi_flasher
`default_nettype wire

// File: tb/tb_pif_multi_flasher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pif_multi_flasher
// Description : Scoreboard bench for pif_multi_flasher (NCH=2, CW=8,
//               PRESCALE=4, PW=4) plus a 3-channel instance for the
//               out-of-range channel case. A reference model derives each
//               channel's phase arithmetically from the number of ticks seen
//               since its last write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pif_multi_flasher;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int P   = 4;
    localparam int PW  = 4;
    localparam int PWR = 16;    // PWM counter period, 2**PW

    logic           xclk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [0:0]     cfg_ch = '0;
    logic [1:0]     cfg_mode = '0;
    logic [CW-1:0]  cfg_on = '0;
    logic [CW-1:0]  cfg_off = '0;
    logic [PW-1:0]  cfg_duty = '0;
    logic           cfg_ready;
    logic [NCH-1:0] led;
    logic           tick;

    logic           cfg_valid3 = 1'b0;
    logic [1:0]     cfg_ch3 = '0;
    logic           cfg_ready3;
    logic [2:0]     led3;
    logic           tick3;

    always #5 xclk = ~xclk;

    pif_multi_flasher #(.NCH(NCH), .CW(CW), .PRESCALE(P), .PW(PW)) dut (
        .xclk(xclk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .cfg_duty(cfg_duty), .led(led), .tick(tick)
    );

    pif_multi_flasher #(.NCH(3), .CW(CW), .PRESCALE(P), .PW(PW)) dut3 (
        .xclk(xclk), .sys_rst(sys_rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .cfg_duty(cfg_duty), .led(led3), .tick(tick3)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // e counts xclk edges since reset release; a = e-2 is the edge index as
    // seen by the synchronised logic (cfg_ready rises after e=2).
    int e = 0;
    bit m_act  [NCH];
    int m_mode [NCH];
    int m_on   [NCH];
    int m_off  [NCH];
    int m_duty [NCH];
    int m_wa   [NCH];

    typedef struct {
        logic [NCH-1:0] led;
        logic           tick;
        logic           ready;
        int             cyc;
    } exp_t;
    exp_t q[$];

    // tick is visible after every edge a that is a positive multiple of P, so a
    // channel consumes ticks at edges b with b-1 a positive multiple of P.
    // Ticks at the write edge itself are ignored (write wins).
    function automatic logic exp_led(input int c, input int a);
        int  n, l1, l0;
        bit  on_ph;
        if (!m_act[c]) return 1'b0;
        l1 = (m_on[c]  == 0) ? 1 : m_on[c];
        l0 = (m_off[c] == 0) ? 1 : m_off[c];
        n  = (a - 1) / P - (m_wa[c] - 1) / P;
        on_ph = (n % (l1 + l0)) < l1;
        case (m_mode[c])
            1:       return 1'b1;
            2:       return on_ph;
            3:       return on_ph && ((a % PWR) < m_duty[c]);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge xclk) begin
        exp_t x;
        int   a;
        if (!sys_rst) begin
            e = 0;
            for (int c = 0; c < NCH; c++) m_act[c] = 1'b0;
        end else begin
            e++;
        end
        a = e - 2;
        if (sys_rst && a >= 1 && cfg_valid && int'(cfg_ch) < NCH) begin
            m_act[cfg_ch]  = 1'b1;
            m_mode[cfg_ch] = int'(cfg_mode);
            m_on[cfg_ch]   = int'(cfg_on);
            m_off[cfg_ch]  = int'(cfg_off);
            m_duty[cfg_ch] = int'(cfg_duty);
            m_wa[cfg_ch]   = a;
        end
        x.tick  = (a >= 1) && (a % P == 0);
        x.ready = (e >= 2);
        for (int c = 0; c < NCH; c++) x.led[c] = (a >= 1) ? exp_led(c, a) : 1'b0;
        x.cyc = e;
        q.push_back(x);
    end

    // ---------------- monitor ----------------
    always @(negedge xclk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk($sformatf("led@e%0d", x.cyc), 32'(led), 32'(x.led));
            chk($sformatf("tick@e%0d", x.cyc), 32'(tick), 32'(x.tick));
            chk($sformatf("cfg_ready@e%0d", x.cyc), 32'(cfg_ready), 32'(x.ready));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge xclk);
            #1;
        end
    endtask

    task automatic do_write(input int ch, input int mode, input int on, input int off, input int duty);
        cfg_valid = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_mode  = 2'(mode);
        cfg_on    = CW'(on);
        cfg_off   = CW'(off);
        cfg_duty  = PW'(duty);
        @(posedge xclk);
        #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        int guard;
        #2 sys_rst = 1'b0;
        idle(3);
        @(negedge xclk);
        #2 sys_rst = 1'b1;
        @(posedge xclk);
        #1;

        // free-running prescaler with no writes
        idle(30);

        // out-of-range channel on the 3-channel instance is dropped
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode = 2'd2; cfg_on = 8'd1; cfg_off = 8'd1;
        @(posedge xclk);
        #1;
        cfg_valid3 = 1'b0;
        repeat (12) begin
            chk("dut3_discard", 32'(led3), 32'd0);
            @(posedge xclk);
            #1;
        end
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd2; cfg_mode = 2'd1;
        @(posedge xclk);
        #1;
        cfg_valid3 = 1'b0;
        chk("dut3_ch2_solid", 32'(led3), 32'd4);

        // blink on=2 off=3
        do_write(0, 2, 2, 3, 0);
        idle(60);

        // PWM blink, duty 4 then duty 0
        do_write(1, 3, 1, 1, 4);
        idle(64);
        do_write(1, 3, 1, 1, 0);
        idle(32);

        // zero-length phases
        do_write(0, 2, 0, 0, 0);
        idle(24);

        // rewrite ch0 on the edge where a tick is consumed; ch1 keeps running
        do_write(1, 2, 3, 2, 0);
        idle(7);
        guard = 0;
        while (((e - 2) % P) != 0 && guard < 2 * P) begin
            @(posedge xclk);
            #1;
            guard++;
        end
        do_write(0, 2, 2, 2, 0);
        idle(30);

        // randomized configuration traffic
        for (int i = 0; i < 40; i++) begin
            do_write($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 15));
            idle($urandom_range(0, 40));
        end

        // reset between edges while ch0 is lit
        do_write(0, 1, 1, 1, 0);
        idle(5);
        @(negedge xclk);
        #2 sys_rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_ready", 32'(cfg_ready), 32'd0);
        chk("async_rst_led3", 32'(led3), 32'd0);
        idle(3);
        @(negedge xclk);
        #2 sys_rst = 1'b1;
        @(posedge xclk);
        #1;
        idle(20);
        chk("post_rst_led3", 32'(led3), 32'd0);

        @(negedge xclk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pif_multi_flasher
`default_nettype wire
